// File: rtl/dcache_if.sv
// dcache_if: bundle of the CPU-side request bus and the physical-memory line
// bus of the data cache.
//   CPU side : mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
//              (requester -> cache); mem_resp, mem_rdata (cache -> requester)
//   Memory   : pmem_address, pmem_read, pmem_write, pmem_wdata
//              (cache -> memory); pmem_rdata, pmem_resp (memory -> cache)
// Modports: slave = the cache, master = the environment (CPU + memory).
interface dcache_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;

    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
//   8 lines x 16 bytes, per-line valid/dirty bits and 9-bit tag.
//   Address split: tag [15:7], index [6:4], word [3:1], bit 0 ignored.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - dcache_if.slave (CPU request bus + physical memory line bus)
//   hit_count, miss_count - 16-bit saturating statistics, present only when
//                           the macro DCACHE_STATS_EN is defined
// Hits respond combinationally in IDLE. A miss walks WRITEBACK (dirty victim)
// and/or FILL, then the request hits in IDLE on the following cycle.
module dcache (
    input  logic      clk,
    input  logic      reset,
    dcache_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t       state;

    logic [127:0] data_arr [8];
    logic [8:0]   tag_arr  [8];
    logic [7:0]   valid;
    logic [7:0]   dirty;

    // Line address captured when leaving IDLE; the miss completes against
    // this even if the CPU changes or drops its request meanwhile.
    logic [11:0]  miss_line;

    logic [2:0]   idx;
    logic [8:0]   tag;
    logic [2:0]   off;
    logic [2:0]   miss_idx;
    logic         req;
    logic         hit;
    logic         resp;
    logic         unused_addr_bit;

    assign idx      = bus.mem_address[6:4];
    assign tag      = bus.mem_address[15:7];
    assign off      = bus.mem_address[3:1];
    assign miss_idx = miss_line[2:0];
    assign unused_addr_bit = bus.mem_address[0];

    always_comb begin
        req  = bus.mem_read | bus.mem_write;
        hit  = valid[idx] && (tag_arr[idx] == tag);
        resp = (state == IDLE) && req && hit;
    end

    assign bus.mem_resp   = resp;
    assign bus.mem_rdata  = data_arr[idx][{off, 4'b0000} +: 16];

    assign bus.pmem_read  = (state == FILL);
    assign bus.pmem_write = (state == WRITEBACK);
    assign bus.pmem_wdata = data_arr[miss_idx];

    always_comb begin
        case (state)
            WRITEBACK: bus.pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
            FILL:      bus.pmem_address = {miss_line, 4'b0000};
            default:   bus.pmem_address = '0;
        endcase
    end

    // Control state: FSM, valid and dirty bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            miss_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (bus.mem_write && (bus.mem_byte_enable != 2'b00))
                                dirty[idx] <= 1'b1;
                        end else begin
                            miss_line <= bus.mem_address[15:4];
                            state     <= (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty[miss_idx] <= 1'b0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; updates are merely suppressed while
    // reset is high so an abandoned fill cannot land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (resp && bus.mem_write) begin
                if (bus.mem_byte_enable[0])
                    data_arr[idx][{off, 4'b0000} +: 8] <= bus.mem_wdata[7:0];
                if (bus.mem_byte_enable[1])
                    data_arr[idx][{off, 4'b1000} +: 8] <= bus.mem_wdata[15:8];
            end
            if ((state == FILL) && bus.pmem_resp) begin
                data_arr[miss_idx] <= bus.pmem_rdata;
                tag_arr[miss_idx]  <= miss_line[11:3];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (resp && (hit_count != '1))
                hit_count <= hit_count + 16'd1;
            if ((state == IDLE) && req && !hit && (miss_count != '1))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
